// File: rtl/des_if.sv
// Beat stream in, word stream out: the handshake bundle between a serializer lane,
// the deserializer and its consumer.
interface des_if #(
    parameter int N = 8,
    parameter int M = 1
);
    logic [M-1:0] rx;
    logic         rx_vld;
    logic         rx_sof;
    logic [N-1:0] dout;
    logic         dout_vld;
    logic         dout_rdy;

    modport master (
        output rx, rx_vld, rx_sof, dout_rdy,
        input  dout, dout_vld
    );

    modport slave (
        input  rx, rx_vld, rx_sof, dout_rdy,
        output dout, dout_vld
    );
endinterface

// File: rtl/des.sv
// Deserializer: rebuilds N-bit words from an LSB-first stream of M-bit beats.
//   state   | meaning
//   IDLE    | waiting for a start-of-frame beat
//   COLLECT | frame in progress, cnt beats already stored
module des #(
    parameter int N = 8,
    parameter int M = 1
) (
    input  logic clk,
    input  logic rst,
    des_if.slave bus,
    output logic busy,
    output logic err_ovr,
    output logic err_trn,
    input  logic err_clr
);
    localparam int BEATS = (N + M - 1) / M;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int SW    = BEATS * M;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] idx;
    logic [SW-1:0] sreg;
    logic [SW-1:0] beat_word;
    logic          take;
    logic          done;
    logic          trn;
    logic [N-1:0]  dout_q;
    logic          dout_vld_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx     = cnt;
        take    = 1'b0;
        done    = 1'b0;
        trn     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_vld && bus.rx_sof) begin
                    take = 1'b1;
                    idx  = '0;
                    if (BEATS == 1) begin
                        done  = 1'b1;
                        cnt_n = '0;
                    end else begin
                        cnt_n   = CW'(1);
                        state_n = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (bus.rx_vld) begin
                    take = 1'b1;
                    if (bus.rx_sof) begin
                        // restart: the current beat becomes beat 0 of a new frame
                        trn   = 1'b1;
                        idx   = '0;
                        cnt_n = CW'(1);
                    end else if (cnt == CW'(BEATS - 1)) begin
                        done    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Beat 0 starts from a clean word so nothing from an abandoned frame survives.
    always_comb begin
        beat_word = (idx == '0) ? '0 : sreg;
        beat_word[32'(idx) * M +: M] = bus.rx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (take) sreg <= beat_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            err_ovr    <= 1'b0;
            err_trn    <= 1'b0;
        end else begin
            if (done && (!dout_vld_q || bus.dout_rdy)) begin
                dout_q     <= beat_word[N-1:0];
                dout_vld_q <= 1'b1;
            end else if (dout_vld_q && bus.dout_rdy) begin
                dout_vld_q <= 1'b0;
            end
            err_ovr <= (done && dout_vld_q && !bus.dout_rdy) || (err_ovr && !err_clr);
            err_trn <= trn || (err_trn && !err_clr);
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign busy         = (state == COLLECT);
endmodule

// File: tb/tb_des.sv
// Bench for des: three instances (M=2, M=1, M=3 at N=8) with a word scoreboard each.
module tb_des;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy2, ovr2, trn2, clr2;
    logic busy1, ovr1, trn1, clr1;
    logic busy3, ovr3, trn3, clr3;

    int n_cmp = 0;
    int n_err = 0;
    int bcnt  = 0;
    int vcnt  = 0;
    logic cnt_en = 1'b0;

    logic [7:0] q2[$];
    logic [7:0] q1[$];
    logic [7:0] q3[$];

    typedef struct {
        logic [7:0] word;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    des_if #(.N(8), .M(2)) i2 ();
    des_if #(.N(8), .M(1)) i1 ();
    des_if #(.N(8), .M(3)) i3 ();

    des #(.N(8), .M(2)) u2 (.clk(clk), .rst(rst), .bus(i2.slave), .busy(busy2),
                            .err_ovr(ovr2), .err_trn(trn2), .err_clr(clr2));
    des #(.N(8), .M(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave), .busy(busy1),
                            .err_ovr(ovr1), .err_trn(trn1), .err_clr(clr1));
    des #(.N(8), .M(3)) u3 (.clk(clk), .rst(rst), .bus(i3.slave), .busy(busy3),
                            .err_ovr(ovr3), .err_trn(trn3), .err_clr(clr3));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cnt_en) begin
            bcnt += int'(busy2);
            vcnt += int'(i2.dout_vld);
        end
    end

    // Scoreboards: a word is consumed wherever dout_vld && dout_rdy is seen.
    always @(negedge clk) begin
        if (!rst && i2.dout_vld && i2.dout_rdy) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_err++;
                $display("FAIL sb2_unexpected: got %h, none expected", i2.dout);
            end else begin
                logic [7:0] e;
                e = q2.pop_front();
                if (i2.dout !== e) begin
                    n_err++;
                    $display("FAIL sb2_word: got %h expected %h", i2.dout, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && i1.dout_vld && i1.dout_rdy) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL sb1_unexpected: got %h, none expected", i1.dout);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (i1.dout !== e) begin
                    n_err++;
                    $display("FAIL sb1_word: got %h expected %h", i1.dout, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && i3.dout_vld && i3.dout_rdy) begin
            n_cmp++;
            if (q3.size() == 0) begin
                n_err++;
                $display("FAIL sb3_unexpected: got %h, none expected", i3.dout);
            end else begin
                logic [7:0] e;
                e = q3.pop_front();
                if (i3.dout !== e) begin
                    n_err++;
                    $display("FAIL sb3_word: got %h expected %h", i3.dout, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        i2.rx_vld = 1'b0;
        i2.rx_sof = 1'b0;
        tick(n);
    endtask

    task automatic send2(input logic [7:0] w, input int gap, input logic rdy_last);
        for (int k = 0; k < 4; k++) begin
            if (k == 3 && rdy_last) i2.dout_rdy = 1'b1;
            i2.rx     = w[2*k +: 2];
            i2.rx_vld = 1'b1;
            i2.rx_sof = (k == 0);
            tick(1);
            if (k == 1 && gap > 0) idle(gap);
        end
        i2.rx_vld = 1'b0;
        i2.rx_sof = 1'b0;
    endtask

    task automatic send1(input logic [7:0] w, input int gap);
        for (int k = 0; k < 8; k++) begin
            i1.rx     = w[k +: 1];
            i1.rx_vld = 1'b1;
            i1.rx_sof = (k == 0);
            tick(1);
            if (k == 3 && gap > 0) begin
                i1.rx_vld = 1'b0;
                i1.rx_sof = 1'b0;
                tick(gap);
            end
        end
        i1.rx_vld = 1'b0;
        i1.rx_sof = 1'b0;
    endtask

    task automatic send3(input logic [8:0] bb);
        for (int k = 0; k < 3; k++) begin
            i3.rx     = bb[3*k +: 3];
            i3.rx_vld = 1'b1;
            i3.rx_sof = (k == 0);
            tick(1);
        end
        i3.rx_vld = 1'b0;
        i3.rx_sof = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((q2.size() != 0 || q1.size() != 0 || q3.size() != 0) && t < 40) begin
            tick(1);
            t++;
        end
        n_cmp++;
        if (t >= 40) begin
            n_err++;
            $display("FAIL %s: %0d words still pending, required 0",
                     name, q2.size() + q1.size() + q3.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{8'h00, 0, 8'h00};
        vecs[1] = '{8'hFF, 1, 8'hFF};
        vecs[2] = '{8'hA5, 2, 8'hA5};
        vecs[3] = '{8'h3C, 0, 8'h3C};
        vecs[4] = '{8'h81, 3, 8'h81};

        i2.rx = '0; i2.rx_vld = 0; i2.rx_sof = 0; i2.dout_rdy = 1;
        i1.rx = '0; i1.rx_vld = 0; i1.rx_sof = 0; i1.dout_rdy = 1;
        i3.rx = '0; i3.rx_vld = 0; i3.rx_sof = 0; i3.dout_rdy = 1;
        clr2 = 0; clr1 = 0; clr3 = 0;

        #12;
        chk("rst_dout", 32'(i2.dout), 0);
        chk("rst_vld", 32'(i2.dout_vld), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_ovr", 32'(ovr2), 0);
        chk("rst_trn", 32'(trn2), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // 0xB4 back-to-back: busy for 3 cycles, one dout_vld pulse
        bcnt = 0; vcnt = 0; cnt_en = 1'b1;
        q2.push_back(8'hB4);
        send2(8'hB4, 0, 1'b0);
        chk("lat_vld", 32'(i2.dout_vld), 1);
        chk("lat_dout", 32'(i2.dout), 32'h B4);
        idle(6);
        cnt_en = 1'b0;
        chk("busy_cycles", 32'(bcnt), 3);
        chk("vld_cycles", 32'(vcnt), 1);

        for (int i = 0; i < 5; i++) begin
            q2.push_back(vecs[i].exp);
            send2(vecs[i].word, vecs[i].gap, 1'b0);
            idle(1);
        end
        drain("drain_table");

        // M=1 with a 2-cycle hole mid-frame
        q1.push_back(8'h5A);
        send1(8'h5A, 2);
        tick(3);
        drain("drain_m1");
        chk("m1_ovr", 32'(ovr1), 0);
        chk("m1_trn", 32'(trn1), 0);

        // M=3: upper bit of the last beat is dropped
        q3.push_back(8'hE3);
        send3({3'b111, 3'b100, 3'b011});
        tick(3);
        drain("drain_m3");

        // overflow while the consumer stalls
        i2.dout_rdy = 1'b0;
        q2.push_back(8'h11);
        send2(8'h11, 0, 1'b0);
        idle(2);
        send2(8'h22, 0, 1'b0);
        idle(2);
        chk("ovr_dout", 32'(i2.dout), 32'h11);
        chk("ovr_vld", 32'(i2.dout_vld), 1);
        chk("ovr_flag", 32'(ovr2), 1);
        i2.dout_rdy = 1'b1;
        tick(1);
        i2.dout_rdy = 1'b0;
        chk("ovr_vld_clr", 32'(i2.dout_vld), 0);
        chk("ovr_q_empty", 32'(q2.size()), 0);
        clr2 = 1'b1;
        tick(1);
        clr2 = 1'b0;
        chk("ovr_cleared", 32'(ovr2), 0);

        // completion on the same edge the held word is taken
        q2.push_back(8'h33);
        send2(8'h33, 0, 1'b0);
        idle(2);
        chk("hold_vld", 32'(i2.dout_vld), 1);
        q2.push_back(8'h44);
        send2(8'h44, 0, 1'b1);
        chk("swap_vld", 32'(i2.dout_vld), 1);
        chk("swap_dout", 32'(i2.dout), 32'h44);
        chk("swap_ovr", 32'(ovr2), 0);
        idle(2);
        drain("drain_swap");

        // set beats clear when they coincide
        i2.dout_rdy = 1'b0;
        q2.push_back(8'h55);
        send2(8'h55, 0, 1'b0);
        idle(2);
        clr2 = 1'b1;
        send2(8'h66, 0, 1'b0);
        clr2 = 1'b0;
        chk("setwins_ovr", 32'(ovr2), 1);
        chk("setwins_dout", 32'(i2.dout), 32'h55);
        i2.dout_rdy = 1'b1;
        idle(2);
        clr2 = 1'b1;
        idle(1);
        clr2 = 1'b0;
        chk("setwins_clr", 32'(ovr2), 0);
        drain("drain_setwins");

        // truncated frame replaced by 0xC3
        bcnt = 0; vcnt = 0; cnt_en = 1'b1;
        i2.rx = 2'b11; i2.rx_vld = 1'b1; i2.rx_sof = 1'b1;
        tick(1);
        i2.rx_sof = 1'b0;
        tick(1);
        q2.push_back(8'hC3);
        send2(8'hC3, 0, 1'b0);
        idle(4);
        cnt_en = 1'b0;
        chk("trn_flag", 32'(trn2), 1);
        chk("trn_vld_cycles", 32'(vcnt), 1);
        chk("trn_ovr", 32'(ovr2), 0);
        drain("drain_trn");

        // asynchronous reset mid-frame
        i2.rx = 2'b11; i2.rx_vld = 1'b1; i2.rx_sof = 1'b1;
        tick(1);
        i2.rx_sof = 1'b0;
        tick(1);
        i2.rx_vld = 1'b0;
        chk("pre_rst_busy", 32'(busy2), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_dout", 32'(i2.dout), 0);
        chk("arst_vld", 32'(i2.dout_vld), 0);
        chk("arst_busy", 32'(busy2), 0);
        chk("arst_trn", 32'(trn2), 0);
        chk("arst_ovr", 32'(ovr2), 0);
        tick(2);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        q2.push_back(8'h7E);
        send2(8'h7E, 0, 1'b0);
        chk("post_rst_dout", 32'(i2.dout), 32'h7E);
        idle(3);
        drain("drain_rst");
        chk("post_rst_trn", 32'(trn2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
